// File: rtl/z88_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : z88_slot_ctrl
//  Description : Multi-slot memory bus controller. Decodes the slot from the
//                top address bits, drives per-slot CE_n and shared OE_n/WE_n,
//                inserts programmable wait states, registers read data and
//                blocks flap-gated or write-protected accesses.
//  Revision    : 1.0  initial release
// ============================================================================
module z88_slot_ctrl #(
    parameter int                      AW        = 22,
    parameter int                      DW        = 8,
    parameter int                      SLOT_BITS = 2,
    parameter int                      WAIT_CYC  = 1,
    parameter logic [(2**SLOT_BITS)-1:0] WP_MASK = 4'b0001,
    parameter logic [DW-1:0]           IDLE_DATA = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req,
    input  logic                            we,
    input  logic [AW-1:0]                   addr,
    input  logic [DW-1:0]                   wdata,
    input  logic                            flap,
    output logic                            ack,
    output logic [DW-1:0]                   rdata,
    output logic                            err,
    output logic                            busy,
    output logic [AW-SLOT_BITS-1:0]         mem_a,
    output logic [DW-1:0]                   mem_di,
    input  logic [(2**SLOT_BITS)*DW-1:0]    mem_do,
    output logic [(2**SLOT_BITS)-1:0]       ce_n,
    output logic                            oe_n,
    output logic                            we_n
);

    localparam int                 c_nslot     = 2**SLOT_BITS;
    localparam logic [c_nslot-1:0] c_ce_idle   = {c_nslot{1'b1}};
    localparam logic [c_nslot-1:0] c_ce_one    = {{(c_nslot-1){1'b0}}, 1'b1};
    localparam logic [3:0]         c_wait_init = 4'(WAIT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    logic [SLOT_BITS-1:0] r_slot;
    logic                 r_we;
    logic [3:0]           r_cnt;

    logic [SLOT_BITS-1:0] w_slot;
    logic                 w_blocked;
    logic [DW-1:0]        w_slot_rdata;

    // Slot decode and access-blocking decision for the request at the bus
    always_comb begin
        w_slot       = addr[AW-1 -: SLOT_BITS];
        w_blocked    = (flap && (w_slot != '0)) || (we && WP_MASK[w_slot]);
        w_slot_rdata = mem_do[32'(r_slot) * DW +: DW];
    end

    // Access sequencer; every bus-facing output is registered here so the
    // strobes are glitch-free and drop immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            ce_n    <= c_ce_idle;
            oe_n    <= 1'b1;
            we_n    <= 1'b1;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= IDLE_DATA;
            mem_a   <= '0;
            mem_di  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        r_slot <= w_slot;
                        r_we   <= we;
                        mem_a  <= addr[AW-SLOT_BITS-1:0];
                        mem_di <= wdata;
                        busy   <= 1'b1;
                        if (w_blocked) begin
                            // Blocked access never touches the bus
                            r_state <= ST_DONE;
                            ack     <= 1'b1;
                            err     <= 1'b1;
                            if (!we) begin
                                rdata <= IDLE_DATA;
                            end
                        end else begin
                            r_state <= ST_SETUP;
                            ce_n    <= ~(c_ce_one << w_slot);
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_cnt   <= c_wait_init;
                    oe_n    <= r_we;
                    we_n    <= ~r_we;
                end
                ST_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_HOLD;
                        oe_n    <= 1'b1;
                        we_n    <= 1'b1;
                        ack     <= 1'b1;
                        err     <= 1'b0;
                        if (!r_we) begin
                            rdata <= w_slot_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    r_state <= ST_IDLE;
                    ce_n    <= c_ce_idle;
                    ack     <= 1'b0;
                    busy    <= 1'b0;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    ce_n    <= c_ce_idle;
                    oe_n    <= 1'b1;
                    we_n    <= 1'b1;
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_z88_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z88_slot_ctrl
//  Description : Directed self-checking bench for z88_slot_ctrl (WAIT_CYC=1
//                main instance, WAIT_CYC=0 instance for back-to-back timing).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_z88_slot_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, req0 = 1'b0;
    logic        we = 1'b0, flap = 1'b0;
    logic [21:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [31:0] mem_do = {8'h3C, 8'hC3, 8'h5A, 8'hA5};

    logic        ack, err, busy, oe_n, we_n;
    logic [7:0]  rdata, mem_di;
    logic [19:0] mem_a;
    logic [3:0]  ce_n;
    logic        ack0, err0, busy0, oe_n0, we_n0;
    logic [7:0]  rdata0, mem_di0;
    logic [19:0] mem_a0;
    logic [3:0]  ce_n0;

    int checks = 0;
    int errors = 0;
    int inv_bad = 0;

    // results of the last access() call
    int          a_edge, a_ce_cnt, a_oe_cnt, a_we_cnt;
    logic        a_err;
    logic [7:0]  a_rdata, a_md;
    logic [3:0]  a_ce_val, a_ce_after;
    logic [19:0] a_ma;

    z88_slot_ctrl #(.WAIT_CYC(1)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .flap(flap), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
        .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do), .ce_n(ce_n),
        .oe_n(oe_n), .we_n(we_n)
    );

    z88_slot_ctrl #(.WAIT_CYC(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .flap(flap), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0),
        .mem_a(mem_a0), .mem_di(mem_di0), .mem_do(mem_do), .ce_n(ce_n0),
        .oe_n(oe_n0), .we_n(we_n0)
    );

    always #5 clk = ~clk;

    // Bus-safety invariants on both instances, sampled away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if ($countones(~ce_n) > 1 || $countones(~ce_n0) > 1) inv_bad <= inv_bad + 1;
            if ((!oe_n && !we_n) || (!oe_n0 && !we_n0)) inv_bad <= inv_bad + 1;
            if ((!oe_n || !we_n) && ce_n == 4'hF) inv_bad <= inv_bad + 1;
            if ((!oe_n0 || !we_n0) && ce_n0 == 4'hF) inv_bad <= inv_bad + 1;
        end
    end

    // One access on the main instance; edge 1 is the first rising edge that sees req
    task automatic access(input logic w, input logic [21:0] a, input logic [7:0] d);
        a_edge = 0; a_ce_cnt = 0; a_oe_cnt = 0; a_we_cnt = 0;
        a_err = 1'b0; a_rdata = 8'h00; a_md = 8'h00; a_ma = '0;
        a_ce_val = 4'hF; a_ce_after = 4'h0;
        @(negedge clk);
        we = w; addr = a; wdata = d; req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (k == 1) begin a_ma = mem_a; a_md = mem_di; end
            if (ce_n != 4'hF) begin a_ce_cnt++; a_ce_val = ce_n; end
            if (!oe_n) a_oe_cnt++;
            if (!we_n) a_we_cnt++;
            if (ack) begin
                a_edge = k; a_err = err; a_rdata = rdata;
                @(negedge clk);
                a_ce_after = ce_n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++; if (ce_n !== 4'hF) begin errors++; $display("FAIL reset_ce_n got %b want 1111", ce_n); end
        checks++; if ({oe_n, we_n} !== 2'b11) begin errors++; $display("FAIL reset_strobes got %b want 11", {oe_n, we_n}); end
        checks++; if ({ack, err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ack, err, busy}); end
        checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL reset_rdata got %h want ff", rdata); end
        checks++; if ({mem_a, mem_di} !== 28'h0) begin errors++; $display("FAIL reset_mem got %h/%h want 0/0", mem_a, mem_di); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_slot0();
        access(1'b0, 22'h000123, 8'h00);
        checks++; if (a_edge !== 4) begin errors++; $display("FAIL rd0_ack_edge got %0d want 4", a_edge); end
        checks++; if (a_ce_cnt !== 4 || a_ce_val !== 4'b1110) begin errors++; $display("FAIL rd0_ce got %0d cycles %b want 4 cycles 1110", a_ce_cnt, a_ce_val); end
        checks++; if (a_oe_cnt !== 2 || a_we_cnt !== 0) begin errors++; $display("FAIL rd0_strobes got oe %0d we %0d want 2/0", a_oe_cnt, a_we_cnt); end
        checks++; if (a_rdata !== 8'hA5 || a_err !== 1'b0) begin errors++; $display("FAIL rd0_data got %h err %b want a5 err 0", a_rdata, a_err); end
        checks++; if (a_ma !== 20'h00123) begin errors++; $display("FAIL rd0_mem_a got %h want 00123", a_ma); end
        checks++; if (a_ce_after !== 4'hF) begin errors++; $display("FAIL rd0_ce_release got %b want 1111", a_ce_after); end
    endtask

    task automatic test_write_slot2();
        access(1'b1, 22'h200010, 8'h3C);
        checks++; if (a_edge !== 4 || a_err !== 1'b0) begin errors++; $display("FAIL wr2_ack got edge %0d err %b want 4/0", a_edge, a_err); end
        checks++; if (a_ce_val !== 4'b1011) begin errors++; $display("FAIL wr2_ce got %b want 1011", a_ce_val); end
        checks++; if (a_we_cnt !== 2 || a_oe_cnt !== 0) begin errors++; $display("FAIL wr2_strobes got we %0d oe %0d want 2/0", a_we_cnt, a_oe_cnt); end
        checks++; if (a_ma !== 20'h00010 || a_md !== 8'h3C) begin errors++; $display("FAIL wr2_bus got %h/%h want 00010/3c", a_ma, a_md); end
        checks++; if (a_rdata !== 8'hA5) begin errors++; $display("FAIL wr2_rdata_hold got %h want a5", a_rdata); end
    endtask

    task automatic test_flap_block();
        flap = 1'b1;
        access(1'b0, 22'h100000, 8'h00);
        checks++; if (a_edge !== 1 || a_err !== 1'b1) begin errors++; $display("FAIL flap_ack got edge %0d err %b want 1/1", a_edge, a_err); end
        checks++; if (a_ce_cnt !== 0 || a_oe_cnt !== 0) begin errors++; $display("FAIL flap_bus got ce %0d oe %0d want 0/0", a_ce_cnt, a_oe_cnt); end
        checks++; if (a_rdata !== 8'hFF) begin errors++; $display("FAIL flap_rdata got %h want ff", a_rdata); end
        flap = 1'b0;
        access(1'b0, 22'h100000, 8'h00);
        checks++; if (a_edge !== 4 || a_err !== 1'b0 || a_rdata !== 8'h5A) begin errors++; $display("FAIL flap_off_rd got edge %0d err %b data %h want 4/0/5a", a_edge, a_err, a_rdata); end
        checks++; if (a_ce_val !== 4'b1101) begin errors++; $display("FAIL flap_off_ce got %b want 1101", a_ce_val); end
    endtask

    task automatic test_write_protect();
        access(1'b0, 22'h3FFFFF, 8'h00);
        checks++; if (a_rdata !== 8'h3C || a_ce_val !== 4'b0111 || a_ma !== 20'hFFFFF) begin errors++; $display("FAIL max_addr got data %h ce %b a %h want 3c/0111/fffff", a_rdata, a_ce_val, a_ma); end
        access(1'b1, 22'h000050, 8'h99);
        checks++; if (a_edge !== 1 || a_err !== 1'b1) begin errors++; $display("FAIL wp_ack got edge %0d err %b want 1/1", a_edge, a_err); end
        checks++; if (a_we_cnt !== 0 || a_ce_cnt !== 0) begin errors++; $display("FAIL wp_bus got we %0d ce %0d want 0/0", a_we_cnt, a_ce_cnt); end
        checks++; if (a_rdata !== 8'h3C) begin errors++; $display("FAIL wp_rdata_hold got %h want 3c", a_rdata); end
        access(1'b0, 22'h000050, 8'h00);
        checks++; if (a_edge !== 4 || a_err !== 1'b0 || a_rdata !== 8'hA5) begin errors++; $display("FAIL wp_rd0 got edge %0d err %b data %h want 4/0/a5", a_edge, a_err, a_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int seen = 0;
        @(negedge clk);
        we = 1'b1; addr = 22'h200010; wdata = 8'h77; req = 1'b1;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        checks++; if (we_n !== 1'b0 || ce_n !== 4'b1011) begin errors++; $display("FAIL abort_pre got we_n %b ce %b want 0/1011", we_n, ce_n); end
        #2 reset = 1'b1;
        #1;
        checks++; if (we_n !== 1'b1 || ce_n !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL abort_async got we_n %b ce %b busy %b want 1/1111/0", we_n, ce_n, busy); end
        @(negedge clk); @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_ack got %0d acks want 0", seen); end
        access(1'b0, 22'h000001, 8'h00);
        checks++; if (a_edge !== 4 || a_rdata !== 8'hA5 || a_err !== 1'b0) begin errors++; $display("FAIL abort_recover got edge %0d data %h err %b want 4/a5/0", a_edge, a_rdata, a_err); end
    endtask

    task automatic test_back_to_back();
        int acks[3] = '{0, 0, 0};
        int n = 0;
        int extra = 0;
        @(negedge clk);
        we = 1'b0; addr = 22'h000040; flap = 1'b0; req0 = 1'b1;
        for (int cyc = 1; cyc <= 40 && n < 3; cyc++) begin
            @(negedge clk);
            if (ack0) begin
                acks[n] = cyc;
                n++;
                if (n == 3) req0 = 1'b0;
            end
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got %0d acks want 3", n); end
        checks++; if (acks[0] !== 3) begin errors++; $display("FAIL b2b_first got edge %0d want 3", acks[0]); end
        checks++; if (acks[1] - acks[0] !== 4 || acks[2] - acks[1] !== 4) begin errors++; $display("FAIL b2b_spacing got %0d,%0d want 4,4", acks[1] - acks[0], acks[2] - acks[1]); end
        checks++; if (rdata0 !== 8'hA5 || err0 !== 1'b0) begin errors++; $display("FAIL b2b_data got %h err %b want a5/0", rdata0, err0); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_stop got %0d extra acks want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_read_slot0();
        test_write_slot2();
        test_flap_block();
        test_write_protect();
        test_reset_mid_access();
        test_back_to_back();
        @(negedge clk);
        checks++; if (inv_bad !== 0) begin errors++; $display("FAIL bus_invariants got %0d violations want 0", inv_bad); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
